// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
// Holds the zero-register number, operand-select encodings and the pipeline slot record.
package hazard_pkg;

    localparam logic [4:0] ZERO_REG = 5'd31;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};

    // The younger producer (EX) wins over the older one (MEM).
    function automatic logic [1:0] fwd_sel(input logic used, input logic hit_ex,
                                           input logic hit_mem);
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && hit_ex)
            sel = FWD_EX;
        else if (used && hit_mem)
            sel = FWD_MEM;
        return sel;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-stage request and hazard/forwarding response bundle.
// master drives the decode fields, slave (the hazard unit) returns stall and selects.
interface fwd_hazard_unit_if;
    logic        id_valid;
    logic [4:0]  id_rn;
    logic [4:0]  id_rm;
    logic        id_rn_used;
    logic        id_rm_used;
    logic [4:0]  id_rd;
    logic        id_wr_en;
    logic        id_is_load;
    logic        flush;
    logic        stall;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_count;

    modport master (
        output id_valid, id_rn, id_rm, id_rn_used, id_rm_used,
               id_rd, id_wr_en, id_is_load, flush,
        input  stall, fwd_a, fwd_b, stall_count
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rn_used, id_rm_used,
               id_rd, id_wr_en, id_is_load, flush,
        output stall, fwd_a, fwd_b, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit_reg_match.sv
// Register-number comparator for one tracking slot against one source operand.
// The zero register never matches, so writes to it are never forwarded.
module reg_match #(
    parameter logic [4:0] ZERO_REG = 5'd31
) (
    input  logic [4:0] slot_rd,
    input  logic       slot_wr,
    input  logic [4:0] r,
    output logic       hit
);

    assign hit = slot_wr && (slot_rd == r) && (r != ZERO_REG);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation for a 5-stage pipeline.
// Optional stall statistics counter built only when STALL_CNT_EN is defined.
module fwd_hazard_unit #(
    parameter logic [4:0] ZERO_REG = hazard_pkg::ZERO_REG
) (
    input  logic              clk,
    input  logic              reset_n,
    fwd_hazard_unit_if.slave  hif
);
    import hazard_pkg::slot_t;
    import hazard_pkg::SLOT_BUBBLE;
    import hazard_pkg::FWD_RF;
    import hazard_pkg::fwd_sel;

    slot_t ex_q;
    slot_t mem_q;
    logic  hit_ex_rn, hit_ex_rm, hit_mem_rn, hit_mem_rm;
    logic  stall;
    logic  [1:0] fwd_a, fwd_b;

    reg_match #(.ZERO_REG(ZERO_REG)) u_match_ex_rn (
        .slot_rd(ex_q.rd),  .slot_wr(ex_q.wr),  .r(hif.id_rn), .hit(hit_ex_rn)
    );
    reg_match #(.ZERO_REG(ZERO_REG)) u_match_ex_rm (
        .slot_rd(ex_q.rd),  .slot_wr(ex_q.wr),  .r(hif.id_rm), .hit(hit_ex_rm)
    );
    reg_match #(.ZERO_REG(ZERO_REG)) u_match_mem_rn (
        .slot_rd(mem_q.rd), .slot_wr(mem_q.wr), .r(hif.id_rn), .hit(hit_mem_rn)
    );
    reg_match #(.ZERO_REG(ZERO_REG)) u_match_mem_rm (
        .slot_rd(mem_q.rd), .slot_wr(mem_q.wr), .r(hif.id_rm), .hit(hit_mem_rm)
    );

    // A load in EX cannot supply data yet; flush outranks the stall.
    assign stall = hif.id_valid && !hif.flush && ex_q.ld &&
                   ((hif.id_rn_used && hit_ex_rn) || (hif.id_rm_used && hit_ex_rm));

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!stall) begin
            fwd_a = fwd_sel(hif.id_rn_used, hit_ex_rn, hit_mem_rn);
            fwd_b = fwd_sel(hif.id_rm_used, hit_ex_rm, hit_mem_rm);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= SLOT_BUBBLE;
            mem_q <= SLOT_BUBBLE;
        end else begin
            mem_q <= ex_q;
            if (stall || hif.flush)
                ex_q <= SLOT_BUBBLE;
            else
                ex_q <= '{rd: hif.id_rd, wr: hif.id_valid & hif.id_wr_en, ld: hif.id_is_load};
        end
    end

    assign hif.stall = stall;
    assign hif.fwd_a = fwd_a;
    assign hif.fwd_b = fwd_b;

`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt_q <= 16'h0000;
        else if (stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign hif.stall_count = stall_cnt_q;
`else
    assign hif.stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Testbench for fwd_hazard_unit: directed pipeline scenarios plus randomized decode
// traffic, compared against an instruction-history reference model.
module tb_fwd_hazard_unit;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    fwd_hazard_unit_if hif ();

    fwd_hazard_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hif     (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the last two instructions that entered the pipe, [0] youngest.
    int  h_rd  [2];
    bit  h_wr  [2];
    bit  h_ld  [2];
    int  m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit produced_by(input int slot, input int r);
        return h_wr[slot] && h_rd[slot] == r && r != 31;
    endfunction

    function automatic logic [1:0] model_fwd(input int r, input bit used);
        if (!used) return 2'b00;
        if (produced_by(0, r)) return 2'b01;
        if (produced_by(1, r)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            h_rd[i] = 0;
            h_wr[i] = 0;
            h_ld[i] = 0;
        end
        m_count = 0;
    endtask

    task automatic step(input bit v, input int rn, input bit rnu, input int rm, input bit rmu,
                        input int rd, input bit we, input bit ld, input bit fl);
        bit          exp_stall;
        logic [1:0]  exp_a, exp_b;
        logic [15:0] exp_cnt;
        @(negedge clk);
        hif.id_valid   = v;
        hif.id_rn      = 5'(rn);
        hif.id_rm      = 5'(rm);
        hif.id_rn_used = rnu;
        hif.id_rm_used = rmu;
        hif.id_rd      = 5'(rd);
        hif.id_wr_en   = we;
        hif.id_is_load = ld;
        hif.flush      = fl;
        #1;
        exp_stall = v && !fl && h_ld[0] &&
                    ((rnu && produced_by(0, rn)) || (rmu && produced_by(0, rm)));
        exp_a = exp_stall ? 2'b00 : model_fwd(rn, rnu);
        exp_b = exp_stall ? 2'b00 : model_fwd(rm, rmu);
`ifdef STALL_CNT_EN
        exp_cnt = 16'(m_count);
`else
        exp_cnt = 16'h0000;
`endif
        check("stall", 32'(hif.stall), 32'(exp_stall));
        check("fwd_a", 32'(hif.fwd_a), 32'(exp_a));
        check("fwd_b", 32'(hif.fwd_b), 32'(exp_b));
        check("stall_count", 32'(hif.stall_count), 32'(exp_cnt));
        h_rd[1] = h_rd[0];
        h_wr[1] = h_wr[0];
        h_ld[1] = h_ld[0];
        if (exp_stall || fl) begin
            h_rd[0] = 0;
            h_wr[0] = 0;
            h_ld[0] = 0;
        end else begin
            h_rd[0] = rd;
            h_wr[0] = v && we;
            h_ld[0] = ld;
        end
        if (exp_stall && m_count < 65535) m_count++;
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int pick_reg();
        int k;
        k = int'($urandom_range(0, 5));
        return (k == 5) ? 31 : k;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        reset_n        = 1'b0;
        hif.id_valid   = 1'b0;
        hif.id_rn      = '0;
        hif.id_rm      = '0;
        hif.id_rn_used = 1'b0;
        hif.id_rm_used = 1'b0;
        hif.id_rd      = '0;
        hif.id_wr_en   = 1'b0;
        hif.id_is_load = 1'b0;
        hif.flush      = 1'b0;
        #12;
        check("reset_stall", 32'(hif.stall), 32'd0);
        check("reset_fwd_a", 32'(hif.fwd_a), 32'd0);
        check("reset_fwd_b", 32'(hif.fwd_b), 32'd0);
        check("reset_count", 32'(hif.stall_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        nop();

        // ADD X1 ; ADD X2,X1,X3
        step(1, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 1, 1, 3, 1, 2, 1, 0, 0);
        check("ex_fwd_a", 32'(hif.fwd_a), 32'd1);
        check("ex_fwd_stall", 32'(hif.stall), 32'd0);

        // writer two back, then writer in both slots
        step(1, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 5, 1, 0, 0);
        step(1, 0, 0, 1, 1, 6, 1, 0, 0);
        check("mem_fwd_b", 32'(hif.fwd_b), 32'd2);
        step(1, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0, 7, 1, 0, 0);
        check("ex_over_mem", 32'(hif.fwd_a), 32'd1);

        // zero register and unused operand
        step(1, 0, 0, 0, 0, 31, 1, 0, 0);
        step(1, 31, 1, 0, 0, 8, 1, 0, 0);
        check("xzr_fwd_a", 32'(hif.fwd_a), 32'd0);
        step(1, 0, 0, 0, 0, 7, 1, 0, 0);
        step(1, 7, 0, 0, 0, 8, 1, 0, 0);
        check("unused_fwd_a", 32'(hif.fwd_a), 32'd0);

        // LDUR X4 ; user of X4 -> one stall, then MEM forward
        step(1, 0, 0, 0, 0, 4, 1, 1, 0);
        step(1, 4, 1, 0, 0, 9, 1, 0, 0);
        check("ldu_stall", 32'(hif.stall), 32'd1);
        step(1, 4, 1, 0, 0, 9, 1, 0, 0);
        check("ldu_release", 32'(hif.stall), 32'd0);
        check("ldu_fwd_a", 32'(hif.fwd_a), 32'd2);
        nop();
`ifdef STALL_CNT_EN
        check("ldu_count", 32'(hif.stall_count), 32'd1);
`else
        check("ldu_count", 32'(hif.stall_count), 32'd0);
`endif

        // load-use with flush in the same cycle
        step(1, 0, 0, 0, 0, 4, 1, 1, 0);
        step(1, 4, 1, 0, 0, 9, 1, 0, 1);
        check("flush_stall", 32'(hif.stall), 32'd0);
        step(1, 9, 1, 9, 1, 10, 1, 0, 0);
        check("flush_bubble_a", 32'(hif.fwd_a), 32'd0);
        check("flush_bubble_b", 32'(hif.fwd_b), 32'd0);

        // reset pulse while stalled
        step(1, 0, 0, 0, 0, 4, 1, 1, 0);
        step(1, 4, 1, 0, 0, 9, 1, 0, 0);
        check("pre_reset_stall", 32'(hif.stall), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_stall", 32'(hif.stall), 32'd0);
        check("rst_fwd_a", 32'(hif.fwd_a), 32'd0);
        check("rst_count", 32'(hif.stall_count), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 4, 1, 4, 1, 9, 1, 0, 0);
        check("rst_discard_a", 32'(hif.fwd_a), 32'd0);

        // randomized decode traffic
        for (int i = 0; i < 600; i++) begin
            bit we, ld;
            we = ($urandom_range(0, 3) != 0);
            ld = we && ($urandom_range(0, 2) == 0);
            step(($urandom_range(0, 7) != 0), pick_reg(), $urandom_range(0, 1),
                 pick_reg(), $urandom_range(0, 1), pick_reg(), we, ld,
                 ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
